psram_wb_rdbuf: RTL and testbench

- Wishbone-to-Wishbone read buffer that sits directly upstream of the PSRAM Wishbone controller.
- Holds a small direct-mapped buffer of aligned 32-bit words, so repeated reads (instruction fetch, polling loops) avoid a full QPI transaction.
- Writes pass through to the controller unchanged (write-through). On completion, the written bytes are merged into the buffer if that word is already resident.
- Only one transaction is outstanding at a time, on both the slave and master sides.

---
 rtl/psram_rdbuf_pkg.sv | 29 ++
 rtl/psram_wb_rdbuf_store.sv | 68 ++++++
 rtl/psram_wb_rdbuf.sv | 209 ++++++++++++++++++++
 tb/tb_psram_wb_rdbuf.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_rdbuf_pkg.sv
// -----------------------------------------------------------------------------
// psram_rdbuf_pkg
// Shared definitions for the PSRAM Wishbone read buffer:
//   - state_t     : FSM state encoding (3 bits) of the buffer controller
//   - FULL_SEL    : byte-select used for every read issued to the controller
//   - rdbuf_idxw  : index width derived from the entry count
//   - rdbuf_tagw  : tag width derived from the forwarded address width
// -----------------------------------------------------------------------------
package psram_rdbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIT  = 3'd1,
        ST_MISS = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [3:0] FULL_SEL = 4'hF;

    function automatic int rdbuf_idxw(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int rdbuf_tagw(input int addr_w, input int entries);
        return addr_w - 2 - $clog2(entries);
    endfunction

endpackage

// File: rtl/psram_wb_rdbuf_store.sv
// -----------------------------------------------------------------------------
// psram_rdbuf_store
// Direct-mapped valid/tag/data storage for the read buffer.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset (valid bits only)
//   lk_idx, lk_tag        combinational lookup address
//   lk_hit, lk_data       lookup result: entry valid with matching tag, word
//   fill_en               write wr_data/wr_tag into wr_idx and mark it valid
//   merge_en              byte-merge wr_data under wr_sel into wr_idx, only if
//                         that entry currently holds wr_tag (no allocate)
//   wr_idx, wr_tag        target entry for fill/merge
//   wr_data, wr_sel       data and byte enables for fill/merge
//   clr                   clear every valid bit; wins over a same-cycle fill
// -----------------------------------------------------------------------------
module psram_rdbuf_store #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = 3,
    parameter int TAGW    = 19
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IDXW-1:0] lk_idx,
    input  logic [TAGW-1:0] lk_tag,
    output logic            lk_hit,
    output logic [31:0]     lk_data,
    input  logic            fill_en,
    input  logic            merge_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_data,
    input  logic [3:0]      wr_sel,
    input  logic            clr
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];
    logic               wr_resident;

    assign lk_hit      = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_data     = data_mem[lk_idx];
    assign wr_resident = valid_q[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    // Only the valid bits need reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end else if (merge_en && wr_resident) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/psram_wb_rdbuf.sv
// -----------------------------------------------------------------------------
// psram_wb_rdbuf
// Wishbone read buffer placed in front of the PSRAM Wishbone controller.
// Reads that hit the direct-mapped buffer are answered in one cycle; misses
// fetch the aligned word from the controller and fill the buffer. Writes are
// forwarded unchanged and merged into the buffer only if the word is resident.
//
// Handshake: a request is s_cyc_i & s_stb_i held by the master until the
// single-cycle s_ack_o; towards the controller m_cyc_o/m_stb_o are held until
// the cycle in which m_ack_i is sampled high and drop on that same edge.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   s_*              Wishbone slave side (from the CPU/bus)
//   m_*              Wishbone master side (to the PSRAM controller)
//   inv_i            single-cycle pulse, invalidates all entries
//   state_o          current FSM state (debug)
//   hit_cnt_o,
//   miss_cnt_o       read hit/miss counters, present only when the
//                    PSRAM_RDBUF_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module psram_wb_rdbuf
    import psram_rdbuf_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [3:0]  s_sel_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    input  logic        inv_i,
    output logic [2:0]  state_o
`ifdef PSRAM_RDBUF_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int IDXW = rdbuf_idxw(ENTRIES);
    localparam int TAGW = rdbuf_tagw(ADDR_W, ENTRIES);

    state_t          state_q;
    logic            abort_q;

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [31:0]     lk_data;
    logic [IDXW-1:0] wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_data;
    logic            fill_en;
    logic            merge_en;
    logic            req;
    logic            read_hit;
    logic            aborted_now;

    assign state_o = state_q;
    assign req     = s_cyc_i & s_stb_i;

    assign lk_idx = s_adr_i[2+IDXW-1:2];
    assign lk_tag = s_adr_i[ADDR_W-1:2+IDXW];

    // A read arriving together with an invalidate is treated as a miss so
    // that no stale word is returned after the flush request.
    assign read_hit = lk_hit & ~inv_i;

    // While a master transaction is in flight the request address is held
    // in m_adr_o, so the fill/merge target is taken from there.
    assign wr_idx   = m_adr_o[2+IDXW-1:2];
    assign wr_tag   = m_adr_o[ADDR_W-1:2+IDXW];
    assign wr_data  = (state_q == ST_MISS) ? m_dat_i : m_dat_o;
    assign fill_en  = (state_q == ST_MISS) && m_ack_i;
    assign merge_en = (state_q == ST_WR) && m_ack_i;

    // The slave may have given up earlier in the transaction or right now.
    assign aborted_now = abort_q | ~s_cyc_i;

    psram_rdbuf_store #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW),
        .TAGW    (TAGW)
    ) u_store (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .lk_idx   (lk_idx),
        .lk_tag   (lk_tag),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
        .fill_en  (fill_en),
        .merge_en (merge_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_sel   (m_sel_o),
        .clr      (inv_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
            s_ack_o <= 1'b0;
            s_dat_o <= '0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s_ack_o <= 1'b0;
                    abort_q <= 1'b0;
                    if (req) begin
                        if (s_we_i) begin
                            state_q <= ST_WR;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b1;
                            m_adr_o <= s_adr_i;
                            m_dat_o <= s_dat_i;
                            m_sel_o <= s_sel_i;
                        end else if (read_hit) begin
                            state_q <= ST_HIT;
                            s_ack_o <= 1'b1;
                            s_dat_o <= lk_data;
                        end else begin
                            state_q <= ST_MISS;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b0;
                            m_adr_o <= {s_adr_i[31:2], 2'b00};
                            m_sel_o <= FULL_SEL;
                        end
                    end
                end

                ST_HIT: begin
                    s_ack_o <= 1'b0;
                    state_q <= ST_IDLE;
                end

                ST_MISS, ST_WR: begin
                    if (!s_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        state_q <= ST_RESP;
                        // The buffer is still updated on abort; only the
                        // slave acknowledge (and read data) is withheld.
                        if (!aborted_now) begin
                            s_ack_o <= 1'b1;
                            if (state_q == ST_MISS) begin
                                s_dat_o <= m_dat_i;
                            end
                        end
                    end
                end

                ST_RESP: begin
                    s_ack_o <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    s_ack_o <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PSRAM_RDBUF_STATS_EN
    // Counted at the lookup decision, so a read aborted later still counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if ((state_q == ST_IDLE) && req && !s_we_i) begin
            if (read_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psram_wb_rdbuf.sv
// -----------------------------------------------------------------------------
// tb_psram_wb_rdbuf
// Directed bench for psram_wb_rdbuf: a table of read/write vectors with
// hand-computed data and hit/miss expectations, followed by hand-written
// sequences for invalidate-during-fill, slave abort and reset mid-write.
// A small PSRAM controller model answers master requests after a fixed
// latency from a word-addressed memory.
// -----------------------------------------------------------------------------
module tb_psram_wb_rdbuf;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    int cyc_n = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    // ---------------- DUT signals ----------------
    logic [31:0] s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_i = '0;
    logic        s_cyc_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_we_i  = 1'b0;
    logic        s_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic        m_ack_i;
    logic        inv_i;
    logic [2:0]  state_o;
`ifdef PSRAM_RDBUF_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    psram_wb_rdbuf #(.ENTRIES(8), .ADDR_W(24)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_adr_i (s_adr_i),
        .s_dat_i (s_dat_i),
        .s_dat_o (s_dat_o),
        .s_sel_i (s_sel_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_ack_o (s_ack_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_sel_o (m_sel_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_ack_i (m_ack_i),
        .inv_i   (inv_i),
        .state_o (state_o)
`ifdef PSRAM_RDBUF_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- PSRAM controller model ----------------
    int          lat = 20;
    bit          inv_req = 1'b0;     // written by the test only
    int          mtx_cnt = 0;        // master transactions seen
    int          ack_cyc = 0;        // cycle number of the last m_ack_i
    logic [31:0] last_adr, last_dat;
    logic [3:0]  last_sel;
    logic        last_we;
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] adr);
        int unsigned k;
        k = int'(adr >> 2);
        if (mem.exists(k)) return mem[k];
        return 32'h0BAD0BAD;
    endfunction

    initial begin : model
        int cnt;
        int unsigned k;
        logic [31:0] v;
        cnt = 0;
        mem[32'h104 >> 2]      = 32'hDEADBEEF;
        mem[32'h004 >> 2]      = 32'h04040404;
        mem[32'h024 >> 2]      = 32'h24242424;
        mem[32'h010 >> 2]      = 32'h11223344;
        mem[32'h020 >> 2]      = 32'h20202020;
        mem[32'h030 >> 2]      = 32'h30303030;
        mem[32'h034 >> 2]      = 32'h34343434;
        mem[32'h040 >> 2]      = 32'h40404040;
        mem[32'h03000044 >> 2] = 32'h44440303;
        mem[32'h05000044 >> 2] = 32'h55550505;
        m_ack_i = 1'b0;
        inv_i   = 1'b0;
        m_dat_i = 32'h0BADF00D;
        forever begin
            @(posedge clk_i);
            #1;
            m_ack_i = 1'b0;
            inv_i   = 1'b0;
            m_dat_i = 32'h0BADF00D;
            if (rst_i) begin
                cnt = 0;
            end else if (m_cyc_o && m_stb_o) begin
                if (cnt == 0) begin
                    mtx_cnt++;
                    last_adr = m_adr_o;
                    last_dat = m_dat_o;
                    last_sel = m_sel_o;
                    last_we  = m_we_o;
                end
                cnt++;
                if (cnt >= lat) begin
                    m_ack_i = 1'b1;
                    ack_cyc = cyc_n;
                    if (m_we_o) begin
                        k = int'(m_adr_o >> 2);
                        v = mem_rd(m_adr_o);
                        for (int b = 0; b < 4; b++)
                            if (m_sel_o[b]) v[8*b +: 8] = m_dat_o[8*b +: 8];
                        mem[k] = v;
                    end else begin
                        m_dat_i = mem_rd(m_adr_o);
                    end
                    inv_i = inv_req;
                    cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_read(input string nm, input logic [31:0] adr,
                           input logic [31:0] exp_d, input bit exp_hit);
        int  m0, n, ack_at;
        bit  got;
        m0 = mtx_cnt;
        s_adr_i = adr; s_we_i = 1'b0; s_sel_i = 4'hF;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        n = 0; got = 1'b0; ack_at = 0;
        while (!got && n < 200) begin
            @(posedge clk_i); #2;
            n++;
            if (s_ack_o) begin got = 1'b1; ack_at = cyc_n; end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        chk({nm, " ack_seen"}, 32'(got), 32'd1);
        chk({nm, " rdata"}, s_dat_o, exp_d);
        if (exp_hit) begin
            chk({nm, " hit_latency"}, n, 32'd1);
            chk({nm, " hit_no_master"}, mtx_cnt - m0, 32'd0);
        end else begin
            chk({nm, " miss_master_cnt"}, mtx_cnt - m0, 32'd1);
            chk({nm, " miss_adr"}, last_adr, {adr[31:2], 2'b00});
            chk({nm, " miss_we"}, 32'(last_we), 32'd0);
            chk({nm, " miss_sel"}, 32'(last_sel), 32'hF);
            chk({nm, " ack_after_mack"}, ack_at, ack_cyc + 1);
        end
        @(posedge clk_i); #2;
        chk({nm, " ack_single"}, 32'(s_ack_o), 32'd0);
        chk({nm, " dat_hold"}, s_dat_o, exp_d);
    endtask

    task automatic do_write(input string nm, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        int  m0, n, ack_at;
        bit  got;
        m0 = mtx_cnt;
        s_adr_i = adr; s_dat_i = dat; s_sel_i = sel; s_we_i = 1'b1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        n = 0; got = 1'b0; ack_at = 0;
        while (!got && n < 200) begin
            @(posedge clk_i); #2;
            n++;
            if (s_ack_o) begin got = 1'b1; ack_at = cyc_n; end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        chk({nm, " ack_seen"}, 32'(got), 32'd1);
        chk({nm, " wr_master_cnt"}, mtx_cnt - m0, 32'd1);
        chk({nm, " wr_we"}, 32'(last_we), 32'd1);
        chk({nm, " wr_adr"}, last_adr, adr);
        chk({nm, " wr_sel"}, 32'(last_sel), 32'(sel));
        chk({nm, " wr_dat"}, last_dat, dat);
        chk({nm, " ack_after_mack"}, ack_at, ack_cyc + 1);
        @(posedge clk_i); #2;
        chk({nm, " ack_single"}, 32'(s_ack_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " s_ack"}, 32'(s_ack_o), 32'd0);
        chk({nm, " s_dat"}, s_dat_o, 32'd0);
        chk({nm, " m_cyc"}, 32'(m_cyc_o), 32'd0);
        chk({nm, " m_stb"}, 32'(m_stb_o), 32'd0);
        chk({nm, " m_we"}, 32'(m_we_o), 32'd0);
        chk({nm, " m_adr"}, m_adr_o, 32'd0);
        chk({nm, " m_dat"}, m_dat_o, 32'd0);
        chk({nm, " m_sel"}, 32'(m_sel_o), 32'd0);
        chk({nm, " state"}, 32'(state_o), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;   // write data, or expected read data
        logic [3:0]  sel;
        bit          hit;   // reads only: expected hit
    } vec_t;

    vec_t vt [18];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        bit seen;
        int m0;

        vt[0]  = '{1'b0, 32'h0000_0104, 32'hDEADBEEF, 4'hF, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0104, 32'hDEADBEEF, 4'hF, 1'b1};
        vt[2]  = '{1'b0, 32'h0000_0004, 32'h04040404, 4'hF, 1'b0};
        vt[3]  = '{1'b0, 32'h0000_0024, 32'h24242424, 4'hF, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_0004, 32'h04040404, 4'hF, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0004, 32'h04040404, 4'hF, 1'b1};
        vt[6]  = '{1'b0, 32'h0000_0010, 32'h11223344, 4'hF, 1'b0};
        vt[7]  = '{1'b1, 32'h0000_0010, 32'h0000AB00, 4'b0010, 1'b0};
        vt[8]  = '{1'b0, 32'h0000_0010, 32'h1122AB44, 4'hF, 1'b1};
        vt[9]  = '{1'b1, 32'h0000_0020, 32'hCAFEF00D, 4'hF, 1'b0};
        vt[10] = '{1'b0, 32'h0000_0020, 32'hCAFEF00D, 4'hF, 1'b0};
        vt[11] = '{1'b0, 32'h0000_0020, 32'hCAFEF00D, 4'hF, 1'b1};
        vt[12] = '{1'b0, 32'h0300_0044, 32'h44440303, 4'hF, 1'b0};
        vt[13] = '{1'b0, 32'h0500_0044, 32'h44440303, 4'hF, 1'b1};
        vt[14] = '{1'b1, 32'h0000_0012, 32'h00CD0000, 4'b0100, 1'b0};
        vt[15] = '{1'b0, 32'h0000_0010, 32'h11CDAB44, 4'hF, 1'b1};
        vt[16] = '{1'b1, 32'h0000_0104, 32'h77000000, 4'b1000, 1'b0};
        vt[17] = '{1'b0, 32'h0500_0044, 32'h44440303, 4'hF, 1'b1};

        // reset state
        repeat (3) @(posedge clk_i);
        #2;
        chk_all_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #2;

        // table-driven vectors
        for (int i = 0; i < 18; i++) begin
            if (vt[i].we)
                do_write($sformatf("vec%0d", i), vt[i].adr, vt[i].dat, vt[i].sel);
            else
                do_read($sformatf("vec%0d", i), vt[i].adr, vt[i].dat, vt[i].hit);
        end

        // invalidate coinciding with a fill: data is returned, entry stays invalid
        inv_req = 1'b1;
        do_read("inv_fill", 32'h30, 32'h30303030, 1'b0);
        inv_req = 1'b0;
        do_read("inv_reread", 32'h30, 32'h30303030, 1'b0);
        do_read("inv_other", 32'h0500_0044, 32'h55550505, 1'b0);

        // slave abort in the middle of a miss
        m0 = mtx_cnt;
        s_adr_i = 32'h34; s_we_i = 1'b0; s_sel_i = 4'hF;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        n = 0;
        while (!m_stb_o && n < 20) begin @(posedge clk_i); #2; n++; end
        chk("abort m_stb_up", 32'(m_stb_o), 32'd1);
        repeat (3) @(posedge clk_i);
        #2;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < lat + 10; c++) begin
            @(posedge clk_i); #2;
            if (s_ack_o) seen = 1'b1;
        end
        chk("abort no_ack", 32'(seen), 32'd0);
        chk("abort master_done", 32'(m_cyc_o), 32'd0);
        chk("abort master_cnt", mtx_cnt - m0, 32'd1);
        do_read("abort_filled", 32'h34, 32'h34343434, 1'b1);

        // reset in the middle of a write
        do_read("rst_pre", 32'h40, 32'h40404040, 1'b0);
        do_read("rst_pre_hit", 32'h40, 32'h40404040, 1'b1);
        s_adr_i = 32'h40; s_dat_i = 32'h99999999; s_sel_i = 4'hF; s_we_i = 1'b1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        n = 0;
        while (!m_stb_o && n < 20) begin @(posedge clk_i); #2; n++; end
        chk("rstwr m_we_up", 32'(m_we_o), 32'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk_all_zero("rst_async");
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i); #2;
        do_read("rst_after", 32'h40, 32'h40404040, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
